jacobian_to_affine: RTL and testbench

- Downstream consumer of mod_inv in the secp256k1 point pipeline.
- Converts a Jacobian point (X, Y, Z) over the field p into affine form: x = X·Z⁻², y = Y·Z⁻³ mod p.
- Obtains Z⁻¹ from a mod_inv instance through a start/done handshake port pair.
- Performs the four remaining field multiplies serially on one internal modular multiplier.

---
 rtl/secp256k1_pkg.sv | 33 +++
 rtl/mod_mul_serial.sv | 117 +++++++++++
 rtl/jacobian_to_affine.sv | 186 ++++++++++++++++++
 tb/tb_jacobian_to_affine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg: shared constants and state encodings for the secp256k1
// point pipeline.
//   W, P       field element width and field prime
//   GX, GY     affine coordinates of the curve generator
//   j2a_state_e  jacobian_to_affine controller states
//   mul_state_e  mod_mul_serial sequencer states
package secp256k1_pkg;

    localparam int W = 256;

    localparam logic [W-1:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [W-1:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHK      = 4'd1,
        ST_INV_REQ  = 4'd2,
        ST_INV_WAIT = 4'd3,
        ST_SQ       = 4'd4,
        ST_MX       = 4'd5,
        ST_CU       = 4'd6,
        ST_MY       = 4'd7,
        ST_FIN      = 4'd8
    } j2a_state_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_LOAD = 2'd1,
        MUL_RUN  = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial interleaved modular multiplier, product = a*b mod P.
//   clk, reset   clock and synchronous active-high reset
//   mul_start    one-cycle request; a and b are captured when it is sampled
//   a, b         operands (a must be < P; b is consumed MSB first)
//   product      result, always < P, valid from mul_done onward
//   mul_done     one-cycle pulse 258 cycles after mul_start is sampled
module mod_mul_serial
    import secp256k1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         mul_start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         mul_done
);

    // Two spare bits keep 2*acc and acc+a (both < 2P) from overflowing.
    localparam logic [W+1:0] P_EXT = {2'b00, P};

    mul_state_e     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W+1:0]   acc_q, acc_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [W-1:0]   prod_q, prod_d;
    logic           done_q, done_d;
    logic [W+1:0]   dbl_s, red1_s, sum_s, step_s;

    // One MSB-first iteration: double, reduce, conditionally add a, reduce.
    always_comb begin
        dbl_s = acc_q << 1'b1;
        if (dbl_s >= P_EXT) begin
            red1_s = dbl_s - P_EXT;
        end else begin
            red1_s = dbl_s;
        end
        if (b_q[W-1]) begin
            sum_s = red1_s + {2'b00, a_q};
        end else begin
            sum_s = red1_s;
        end
        if (sum_s >= P_EXT) begin
            step_s = sum_s - P_EXT;
        end else begin
            step_s = sum_s;
        end
    end

    // Sequencer: capture, clear accumulator, run 256 iterations, pulse done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (mul_start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL_LOAD;
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_LOAD: begin
                acc_d   = {(W+2){1'b0}};
                cnt_d   = 8'd0;
                state_d = MUL_RUN;
            end
            MUL_RUN: begin
                acc_d = step_s;
                b_d   = {b_q[W-2:0], 1'b0};
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) begin
                    prod_d  = step_s[W-1:0];
                    done_d  = 1'b1;
                    state_d = MUL_IDLE;
                end else begin
                    state_d = MUL_RUN;
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MUL_IDLE;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            acc_q   <= {(W+2){1'b0}};
            cnt_q   <= 8'd0;
            prod_q  <= {W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign product  = prod_q;
    assign mul_done = done_q;

endmodule

// File: rtl/jacobian_to_affine.sv
// jacobian_to_affine: converts a Jacobian point (X, Y, Z) to affine
// x = X*Z^-2, y = Y*Z^-3 mod P, using an external mod_inv for Z^-1 and one
// serial multiplier for the four remaining products.
//   start / X_in, Y_in, Z_in    request and operands (latched on accept)
//   x_out, y_out, infinity      result, valid from done until the next accept
//   done, busy                  completion pulse and activity flag
//   inv_start, inv_in           request and operand to mod_inv
//   inv_result, inv_done        mod_inv response
module jacobian_to_affine
    import secp256k1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] X_in,
    input  logic [W-1:0] Y_in,
    input  logic [W-1:0] Z_in,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         infinity,
    output logic         done,
    output logic         busy,
    output logic         inv_start,
    output logic [W-1:0] inv_in,
    input  logic [W-1:0] inv_result,
    input  logic         inv_done
);

    j2a_state_e   state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [W-1:0] zi_q, zi_d, t_q, t_d;
    logic         issued_q, issued_d;
    logic [W-1:0] x_out_q, x_out_d, y_out_q, y_out_d, inv_in_q, inv_in_d;
    logic         inf_q, inf_d, done_q, done_d, busy_q, busy_d;
    logic         inv_start_q, inv_start_d;
    logic         mul_start_s, mul_done_s;
    logic [W-1:0] mul_a_s, mul_b_s, mul_prod_s;

    mod_mul_serial u_mul (
        .clk       (clk),
        .reset     (reset),
        .mul_start (mul_start_s),
        .a         (mul_a_s),
        .b         (mul_b_s),
        .product   (mul_prod_s),
        .mul_done  (mul_done_s)
    );

    // Multiplier operand select per multiply phase.
    always_comb begin
        mul_a_s = zi_q;
        mul_b_s = zi_q;
        case (state_q)
            ST_MX:   begin mul_a_s = x_q; mul_b_s = t_q;  end
            ST_CU:   begin mul_a_s = t_q; mul_b_s = zi_q; end
            ST_MY:   begin mul_a_s = y_q; mul_b_s = t_q;  end
            default: begin mul_a_s = zi_q; mul_b_s = zi_q; end
        endcase
    end

    // Controller next state; outputs are registered to line up with the state entered.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zi_d        = zi_q;
        t_d         = t_q;
        issued_d    = issued_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        inf_d       = inf_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = X_in;
                    y_d     = Y_in;
                    z_d     = Z_in;
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (z_q == {W{1'b0}}) begin
                    x_out_d = {W{1'b0}};
                    y_out_d = {W{1'b0}};
                    inf_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    inf_d   = 1'b0;
                    state_d = ST_INV_REQ;
                end
            end
            ST_INV_REQ: begin
                state_d = ST_INV_WAIT;
            end
            ST_INV_WAIT: begin
                if (inv_done) begin
                    zi_d     = inv_result;
                    issued_d = 1'b0;
                    state_d  = ST_SQ;
                end else begin
                    state_d = ST_INV_WAIT;
                end
            end
            ST_SQ, ST_MX, ST_CU, ST_MY: begin
                // First cycle of a phase issues the multiply; then wait for its done.
                if (!issued_q) begin
                    mul_start_s = 1'b1;
                    issued_d    = 1'b1;
                end else if (mul_done_s) begin
                    issued_d = 1'b0;
                    case (state_q)
                        ST_SQ:   begin t_d = mul_prod_s;     state_d = ST_MX;  end
                        ST_MX:   begin x_out_d = mul_prod_s; state_d = ST_CU;  end
                        ST_CU:   begin t_d = mul_prod_s;     state_d = ST_MY;  end
                        ST_MY:   begin y_out_d = mul_prod_s; state_d = ST_FIN; end
                        default: begin state_d = ST_IDLE; end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d      = (state_d == ST_FIN);
        busy_d      = (state_d != ST_IDLE);
        inv_start_d = (state_d == ST_INV_REQ);
        if (state_d == ST_INV_REQ) begin
            inv_in_d = z_q;
        end else begin
            inv_in_d = inv_in_q;
        end
    end

    // Controller and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= {W{1'b0}};
            y_q         <= {W{1'b0}};
            z_q         <= {W{1'b0}};
            zi_q        <= {W{1'b0}};
            t_q         <= {W{1'b0}};
            issued_q    <= 1'b0;
            x_out_q     <= {W{1'b0}};
            y_out_q     <= {W{1'b0}};
            inf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            inv_start_q <= 1'b0;
            inv_in_q    <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zi_q        <= zi_d;
            t_q         <= t_d;
            issued_q    <= issued_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            inf_q       <= inf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            inv_start_q <= inv_start_d;
            inv_in_q    <= inv_in_d;
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign infinity  = inf_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign inv_start = inv_start_q;
    assign inv_in    = inv_in_q;

endmodule

// File: tb/tb_jacobian_to_affine.sv
// tb_jacobian_to_affine: directed self-checking bench for jacobian_to_affine
// and its mod_mul_serial multiplier, with a behavioural mod_inv responder.
module tb_jacobian_to_affine;

    localparam logic [255:0] P_T   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX_T  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY_T  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] HALF1 = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;
    localparam int INV_LAT = 5;
    localparam int PIPE    = 4 * 259 + 1;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [255:0] X_in, Y_in, Z_in, x_out, y_out, inv_in;
    logic         infinity, done, busy, inv_start;
    logic [255:0] inv_result = 256'd0;
    logic         inv_done   = 1'b0;
    logic         mt_start;
    logic [255:0] mt_a, mt_b, mt_prod;
    logic         mt_done;

    int cyc = 0;
    int done_cnt = 0;
    int inv_req_cnt = 0;
    int inv_cd = 0;
    int inv_done_cyc = 0;
    bit inv_mode = 1'b0;
    logic [255:0] inv_op = 256'd0;
    int n_checks = 0;
    int n_fail = 0;

    jacobian_to_affine u_dut (
        .clk(clk), .reset(reset), .start(start),
        .X_in(X_in), .Y_in(Y_in), .Z_in(Z_in),
        .x_out(x_out), .y_out(y_out), .infinity(infinity),
        .done(done), .busy(busy), .inv_start(inv_start), .inv_in(inv_in),
        .inv_result(inv_result), .inv_done(inv_done)
    );

    mod_mul_serial u_mul (
        .clk(clk), .reset(reset), .mul_start(mt_start),
        .a(mt_a), .b(mt_b), .product(mt_prod), .mul_done(mt_done)
    );

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (inv_start) inv_req_cnt = inv_req_cnt + 1;
    end

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        t = t % {256'd0, P_T};
        return t[255:0];
    endfunction

    // Fermat inverse z^(P-2) mod P.
    function automatic logic [255:0] modinv(input logic [255:0] z);
        logic [255:0] r, base, e;
        r = 256'd1;
        base = z;
        e = P_T - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, base);
            base = mulmod(base, base);
        end
        return r;
    endfunction

    // Behavioural mod_inv: answers INV_LAT cycles after inv_start.
    always @(posedge clk) begin
        #1;
        inv_done = 1'b0;
        if (inv_cd > 0) begin
            inv_cd = inv_cd - 1;
            if (inv_cd == 0) begin
                inv_done = 1'b1;
                inv_result = inv_mode ? modinv(inv_op) : 256'd1;
                inv_done_cyc = cyc;
            end
        end
        if (inv_start) begin
            inv_op = inv_in;
            inv_cd = INV_LAT;
        end
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mul_case(input string tag, input logic [255:0] av, input logic [255:0] bv,
                            input logic [255:0] exp);
        int s0;
        int lat;
        @(posedge clk); #1;
        mt_a = av; mt_b = bv; mt_start = 1'b1; s0 = cyc; lat = -1;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk); #1;
            mt_start = 1'b0; mt_a = ~av; mt_b = ~bv;
            if (mt_done) begin lat = cyc - s0; break; end
        end
        check_val({tag, "_lat"}, 256'(lat), 256'd258);
        check_val({tag, "_prod"}, mt_prod, exp);
    endtask

    // Issue one request, optionally pulsing start in INV_WAIT and MX, and wait for done.
    task automatic run_op(input logic [255:0] xv, input logic [255:0] yv, input logic [255:0] zv,
                          input bit disturb, output int s0, output int lat, output int pulses);
        int n0;
        @(posedge clk); #1;
        X_in = xv; Y_in = yv; Z_in = zv; start = 1'b1;
        s0 = cyc; n0 = done_cnt; lat = -1;
        for (int i = 1; i < 1300; i++) begin
            @(posedge clk); #1;
            start = (disturb && (i == 4 || i == 400)) ? 1'b1 : 1'b0;
            X_in = ~xv; Y_in = ~yv; Z_in = ~zv;
            if (done) begin lat = cyc - s0; break; end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulses = done_cnt - n0;
    endtask

    task automatic check_point(input string tag, input bit disturb, input logic [255:0] xv,
                               input logic [255:0] yv, input logic [255:0] zv, input bit mode);
        int s0, lat, pulses;
        inv_mode = mode;
        run_op(xv, yv, zv, disturb, s0, lat, pulses);
        check_val({tag, "_x"}, x_out, GX_T);
        check_val({tag, "_y"}, y_out, GY_T);
        check_val({tag, "_inf"}, 256'(infinity), 256'd0);
        check_val({tag, "_lat"}, 256'(lat), 256'(2 + INV_LAT + PIPE));
        check_val({tag, "_invdone_to_done"}, 256'(s0 + lat - inv_done_cyc), 256'(PIPE));
        check_val({tag, "_pulses"}, 256'(pulses), 256'd1);
        check_val({tag, "_busy_after"}, 256'(busy), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, lat, pulses, n0, inv0;
        reset = 1'b1; start = 1'b0;
        X_in = 256'd0; Y_in = 256'd0; Z_in = 256'd0;
        mt_start = 1'b0; mt_a = 256'd0; mt_b = 256'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_x", x_out, 256'd0);
        check_val("rst_y", y_out, 256'd0);
        check_val("rst_flags", {251'd0, infinity, done, busy, inv_start, mt_done}, 256'd0);
        check_val("rst_inv_in", inv_in, 256'd0);
        reset = 1'b0;

        mul_case("mul_pm1_sq", P_T - 256'd1, P_T - 256'd1, 256'd1);
        mul_case("mul_zero", 256'd0, GX_T, 256'd0);
        mul_case("mul_2_half", 256'd2, HALF1, 256'd1);

        check_point("gen_z1", 1'b0, GX_T, GY_T, 256'd1, 1'b0);
        check_point("gen_z2", 1'b0, mulmod(GX_T, 256'd4), mulmod(GY_T, 256'd8), 256'd2, 1'b1);

        inv0 = inv_req_cnt;
        run_op(GX_T, GY_T, 256'd0, 1'b0, s0, lat, pulses);
        check_val("zinf_lat", 256'(lat), 256'd2);
        check_val("zinf_inf", 256'(infinity), 256'd1);
        check_val("zinf_x", x_out, 256'd0);
        check_val("zinf_y", y_out, 256'd0);
        check_val("zinf_pulses", 256'(pulses), 256'd1);
        check_val("zinf_no_inv", 256'(inv_req_cnt - inv0), 256'd0);

        check_point("disturbed", 1'b1, GX_T, GY_T, 256'd1, 1'b0);

        // Reset for one cycle while in CU, then a fresh request.
        inv_mode = 1'b0;
        @(posedge clk); #1;
        X_in = GX_T; Y_in = GY_T; Z_in = 256'd1; start = 1'b1;
        s0 = cyc; n0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s0 + 600) begin @(posedge clk); #1; end
        check_val("pre_rst_busy", 256'(busy), 256'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("mid_rst_x", x_out, 256'd0);
        check_val("mid_rst_y", y_out, 256'd0);
        check_val("mid_rst_flags", {252'd0, infinity, done, busy, inv_start}, 256'd0);
        repeat (800) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", 256'(done_cnt - n0), 256'd0);
        check_point("after_rst", 1'b0, mulmod(GX_T, 256'd4), mulmod(GY_T, 256'd8), 256'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
